// File: rtl/add_sub_pkg.sv
// Shared constants and types for the add_sub block.
// Optional flag outputs (zf, nf) are enabled by defining ADD_SUB_FLAGS_EN.
package add_sub_pkg;

    // Default operand/result width. The legal range is 2..32.
    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 32;

    // One registered result. z is sized for the widest legal configuration;
    // narrower instances use only the low WIDTH bits.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] z;
        logic                 co;
        logic                 oflow;
    } result_t;

endpackage

// File: rtl/add_sub_fa_cell.sv
// One-bit full adder built from gate primitives. It is one stage of the
// ripple-carry chain inside add_sub.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;
    logic g;
    logic t;

    xor u_p (p, a, b);
    xor u_s (s, p, ci);
    and u_g (g, a, b);
    and u_t (t, p, ci);
    or  u_c (co, g, t);

endmodule

// File: rtl/add_sub.sv
// Registered ripple-carry adder/subtractor with carry-in, carry-out and
// signed overflow. The result is registered with a latency of one cycle.
// Define ADD_SUB_FLAGS_EN to add the registered zero (zf) and negative (nf)
// flag outputs.
module add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             sub,
    input  logic             ci,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] z,
    output logic             co,
    output logic             oflow
`ifdef ADD_SUB_FLAGS_EN
    ,
    output logic             zf,
    output logic             nf
`endif
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    // Subtraction inverts b. The caller supplies the +1 through ci.
    assign b_eff    = b ^ {WIDTH{sub}};
    assign carry[0] = ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fa_cell u_fa (
            .a  (a[i]),
            .b  (b_eff[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    // Valid pipeline: out_valid follows in_valid by exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            // NOTE: registers use non-blocking assignment so that every flop
            // samples its inputs as they were before the clock edge.
            out_valid <= in_valid;
        end
    end

    // Result registers: load on in_valid and hold otherwise. Overflow XORs the
    // carries out of cells WIDTH-2 and WIDTH-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z     <= '0;
            co    <= 1'b0;
            oflow <= 1'b0;
        end else if (in_valid) begin
            z     <= sum;
            co    <= carry[WIDTH];
            oflow <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

`ifdef ADD_SUB_FLAGS_EN
    // Flags are computed from the same sum and loaded and held together with z.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zf <= 1'b0;
            nf <= 1'b0;
        end else if (in_valid) begin
            zf <= (sum == '0);
            nf <= sum[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub. It runs directed vectors, an exhaustive
// sweep with a mid-stream reset, and random traffic. All checks use an
// arithmetic reference model.
module tb_add_sub;
    import add_sub_pkg::*;

    localparam int W    = 4;
    localparam int HALF = 1 << (W - 1);
    localparam int MOD  = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         sub = 1'b0;
    logic         ci = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic [W-1:0] z;
    logic         co;
    logic         oflow;
`ifdef ADD_SUB_FLAGS_EN
    logic         zf;
    logic         nf;
`endif

    int      n_cmp = 0;
    int      n_err = 0;
    result_t exp_res = '0;
    logic    exp_valid = 1'b0;

    add_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .sub       (sub),
        .ci        (ci),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .z         (z),
        .co        (co),
        .oflow     (oflow)
`ifdef ADD_SUB_FLAGS_EN
        ,
        .zf        (zf),
        .nf        (nf)
`endif
    );

    always #5 clk = ~clk;

    // Reference model. The unsigned sum gives z and co. Signed overflow means
    // the true signed sum falls outside the W-bit two's-complement range.
    function automatic result_t model(input logic s, input logic c,
                                      input logic [W-1:0] x, input logic [W-1:0] y);
        result_t r;
        int ux;
        int uy;
        int full;
        int sx;
        int sy;
        int sres;
        ux   = int'(x);
        uy   = s ? (MOD - 1 - int'(y)) : int'(y);
        full = ux + uy + int'(c);
        sx   = (ux >= HALF) ? ux - MOD : ux;
        sy   = (uy >= HALF) ? uy - MOD : uy;
        sres = sx + sy + int'(c);
        r       = '0;
        r.z     = 32'(full % MOD);
        r.co    = (full >= MOD);
        r.oflow = (sres > HALF - 1) || (sres < -HALF);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [W-1:0] ez;
        ez = exp_res.z[W-1:0];
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
        chk({tag, ".z"},         32'(z),         32'(ez));
        chk({tag, ".co"},        32'(co),        32'(exp_res.co));
        chk({tag, ".oflow"},     32'(oflow),     32'(exp_res.oflow));
`ifdef ADD_SUB_FLAGS_EN
        chk({tag, ".zf"},        32'(zf),        32'(ez == '0));
        chk({tag, ".nf"},        32'(nf),        32'(ez[W-1]));
`endif
    endtask

    // Drive one cycle of inputs on the falling edge. Update the model after the
    // rising edge, then check the outputs.
    task automatic drive(input string tag, input logic v, input logic s, input logic c,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        in_valid = v;
        sub      = s;
        ci       = c;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        if (v) exp_res = model(s, c, x, y);
        exp_valid = v;
        check_outputs(tag);
    endtask

    // Directed vector: check against the model and also against fixed expected values.
    task automatic directed(input string tag, input logic s, input logic c,
                            input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] ez, input logic eco, input logic eof);
        drive(tag, 1'b1, s, c, x, y);
        chk({tag, ".z_const"},     32'(z),     32'(ez));
        chk({tag, ".co_const"},    32'(co),    32'(eco));
        chk({tag, ".oflow_const"}, 32'(oflow), 32'(eof));
    endtask

    initial begin
        // Asynchronous reset with no clock edge.
        #1 rst = 1'b1;
        #1;
        exp_res   = '0;
        exp_valid = 1'b0;
        check_outputs("reset_async");
        @(negedge clk);
        rst = 1'b0;

        // Idle cycle after reset: nothing valid and all outputs stay zero.
        drive("idle_after_reset", 1'b0, 1'b0, 1'b0, 4'd9, 4'd3);

        // Directed corner cases.
        directed("add_7_1",      1'b0, 1'b0, 4'd7,  4'd1,  4'd8,  1'b0, 1'b1);
        directed("sub_3_5",      1'b1, 1'b1, 4'd3,  4'd5,  4'd14, 1'b0, 1'b0);
        directed("sub_8_1",      1'b1, 1'b1, 4'd8,  4'd1,  4'd7,  1'b1, 1'b1);
        directed("add_15_15_c1", 1'b0, 1'b1, 4'd15, 4'd15, 4'd15, 1'b1, 1'b0);
`ifdef ADD_SUB_FLAGS_EN
        chk("add_15_15_c1.nf_const", 32'(nf), 32'(1));
        chk("add_15_15_c1.zf_const", 32'(zf), 32'(0));
`endif
        directed("sub_borrow_in", 1'b1, 1'b0, 4'd5, 4'd2,  4'd2,  1'b1, 1'b0);
        directed("add_zero_wrap", 1'b0, 1'b0, 4'd8, 4'd8,  4'd0,  1'b1, 1'b1);

        // Hold: when in_valid is low, z, co and oflow keep their values.
        drive("hold_0", 1'b0, 1'b1, 1'b1, 4'd1, 4'd9);
        drive("hold_1", 1'b0, 1'b0, 1'b1, 4'd6, 4'd6);

        // Exhaustive sweep of {sub, a, b} with ci = sub, one operation per
        // cycle. An asynchronous reset pulse is inserted halfway through.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] idx;
            idx = 9'(i);
            drive("sweep", 1'b1, idx[8], idx[8], idx[7:4], idx[3:0]);
            if (i == 255) begin
                #2 rst = 1'b1;
                #1;
                exp_res   = '0;
                exp_valid = 1'b0;
                check_outputs("mid_reset");
                rst = 1'b0;
                drive("post_reset_idle", 1'b0, 1'b0, 1'b0, 4'd3, 4'd4);
            end
        end

        // Random traffic with gaps in in_valid and independent sub/ci.
        for (int i = 0; i < 200; i++) begin
            drive("random", ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  W'($urandom), W'($urandom));
        end

        drive("final_idle", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/add_sub.md
ADD_SUB -- requirements
Module: add_sub

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, operand/result bit width (legal range 2..32).
REQ-002 SHALL provide port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port in_valid  input  1  operands/controls valid this cycle.
REQ-005 SHALL provide port sub  input  1  0 = add, 1 = subtract (b inverted).
REQ-006 SHALL provide port ci  input  1  carry-in to bit 0 (drive equal to sub for plain two's-complement subtract).
REQ-007 SHALL provide port a  input  WIDTH  operand A.
REQ-008 SHALL provide port b  input  WIDTH  operand B.
REQ-009 SHALL provide port out_valid  output  1  registered result valid.
REQ-010 SHALL provide port z  output  WIDTH  registered sum/difference.
REQ-011 SHALL provide port co  output  1  registered carry out of MSB (subtract: 1 = no borrow).
REQ-012 SHALL provide port oflow  output  1  registered signed two's-complement overflow.

Function
REQ-013 SHALL form b_eff = b XOR {WIDTH{sub}}.
REQ-014 SHALL compute {co, z} = a + b_eff + ci, unsigned, WIDTH+1 bits, no truncation of carry.
REQ-015 SHALL compute oflow = carry into MSB XOR carry out of MSB.
REQ-016 sub=1, ci=0 SHALL yield a - b - 1 (borrow-in semantics); sub=0, ci=1 SHALL yield a + b + 1.
REQ-017 SHALL register z, co, oflow on the rising clk edge when in_valid=1; latency exactly 1 cycle.
REQ-018 out_valid SHALL be in_valid delayed by one cycle.
REQ-019 When in_valid=0, z, co, oflow SHALL hold their previous values.
REQ-020 Wrap-around SHALL be modulo 2^WIDTH on z with no saturation.
REQ-021 Back-to-back in_valid SHALL give one result per cycle with no bubbles.

Reset
REQ-022 rst=1 SHALL immediately clear out_valid, z, co, oflow (and zf, nf when compiled in) to 0, independent of clk.
REQ-023 Reset asserted mid-stream SHALL discard the in-flight result; first valid output SHALL appear one cycle after the first in_valid following deassertion.

Configuration
REQ-024 With macro ADD_SUB_FLAGS_EN defined, SHALL add outputs zf (1 = registered z is all zeros) and nf (= registered z[WIDTH-1]), registered and held with z.
REQ-025 Without ADD_SUB_FLAGS_EN, zf and nf ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-026 Shared package add_sub_pkg SHALL hold default WIDTH constant and a result struct type {z, co, oflow}.
REQ-027 Datapath SHALL be a ripple chain of WIDTH instances of sub-module fa_cell (1-bit full adder: a, b, ci -> s, co), gate-level.
REQ-028 oflow SHALL use the carry out of cell WIDTH-2 and cell WIDTH-1.

Verification
REQ-029 WIDTH=4, a=7, b=1, sub=0, ci=0 -> next cycle z=8, co=0, oflow=1, out_valid=1.
REQ-030 a=3, b=5, sub=1, ci=1 -> z=14, co=0, oflow=0.
REQ-031 a=8, b=1, sub=1, ci=1 -> z=7, co=1, oflow=1.
REQ-032 a=15, b=15, sub=0, ci=1 -> z=15, co=1, oflow=0; with ADD_SUB_FLAGS_EN nf=1, zf=0.
REQ-033 Exhaustive sweep of all 512 combinations {sub, a, b}, ci=sub, one per cycle -> every z/co/oflow matches a behavioural a+b_eff+ci model; zero mismatches.
REQ-034 Assert rst for 1 ns mid-sweep -> outputs 0 immediately; out_valid returns one cycle after next in_valid.
